// File: rtl/sobel_deadlock_pkg.sv
// sobel_deadlock_pkg: shared state encoding, default sizes and index width for the deadlock supervisor
package sobel_deadlock_pkg;
  localparam int N_MON_DEF = 4;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int IDX_W_DEF = idx_w(N_MON_DEF);
endpackage

// File: rtl/sobel_deadlock_rr_arb.sv
// sobel_deadlock_rr_arb: combinational round-robin pick of the first request after last_grant
module sobel_deadlock_rr_arb
  import sobel_deadlock_pkg::*;
#(
  parameter int N  = N_MON_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);
  int j;
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    j           = 0;
    // walk from farthest to nearest so the closest request after last_grant is written last
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_grant_i) + k) % N;
      if (req_i[j]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sobel_deadlock_supervisor.sv
// sobel_deadlock_supervisor: confirms persistent monitor blocks and reports each one once via valid/ready
module sobel_deadlock_supervisor
  import sobel_deadlock_pkg::*;
#(
  parameter int N_MON = N_MON_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int IW   = idx_w(N_MON)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_MON-1:0] mon_block,
  input  logic [CNT_W-1:0] cfg_threshold,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [IW-1:0]    report_idx,
  output logic [CNT_W-1:0] report_cycles,
  output logic             deadlock,
  output logic             busy
);
  logic [CNT_W-1:0] cnt_q [N_MON];
  logic [N_MON-1:0] confirmed, pending, reported_q, reported_d;
  logic [CNT_W-1:0] thr;
  logic [IW-1:0]    last_q, idx_q, gnt_idx;
  logic [CNT_W-1:0] cyc_q;
  logic             valid_q, dl_q, gnt_valid, hs;
  state_e           state_q;

  assign thr = cfg_threshold == '0 ? CNT_W'(1) : cfg_threshold;
  assign hs  = state_q == REPORT && valid_q && report_ready;

  always_ff @(posedge clock) begin
    for (int k = 0; k < N_MON; k++)
      cnt_q[k] <= reset || !(mon_block[k] && enable) ? '0 : cnt_q[k] + CNT_W'(!(&cnt_q[k]));
  end

  always_comb begin
    for (int k = 0; k < N_MON; k++) confirmed[k] = cnt_q[k] >= thr;
    pending    = confirmed & ~reported_q;
    reported_d = reported_q;
    if (hs) reported_d[idx_q] = 1'b1;
    // a released monitor re-arms, even on the cycle its report is accepted
    reported_d = reported_d & mon_block;
  end

  sobel_deadlock_rr_arb #(.N(N_MON), .IW(IW)) u_arb (
    .req_i        (pending),
    .last_grant_i (last_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= IW'(N_MON - 1);
      idx_q      <= '0;
      cyc_q      <= '0;
      valid_q    <= 1'b0;
      dl_q       <= 1'b0;
      reported_q <= '0;
    end else begin
      dl_q       <= |confirmed;
      reported_q <= reported_d;
      case (state_q)
        IDLE: state_q <= enable ? SCAN : IDLE;
        SCAN: begin
          if (!enable) state_q <= IDLE;
          else if (gnt_valid) begin
            idx_q   <= gnt_idx;
            cyc_q   <= cnt_q[gnt_idx];
            state_q <= REPORT;
          end
        end
        REPORT: begin
          if (hs) begin
            valid_q <= 1'b0;
            last_q  <= idx_q;
            state_q <= enable ? SCAN : IDLE;
          end else valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign report_valid  = valid_q;
  assign report_idx    = idx_q;
  assign report_cycles = cyc_q;
  assign deadlock      = dl_q;
  assign busy          = state_q != IDLE;
endmodule

// File: doc/sobel_deadlock_supervisor.md
SOBEL_DEADLOCK_SUPERVISOR -- requirements
Module: sobel_deadlock_supervisor

Interface
REQ-001 SHALL have parameter N_MON, default 4, number of per-loop deadlock monitor block flags supervised.
REQ-002 SHALL have parameter CNT_W, default 16, width of persistence counters and threshold.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  supervision enable.
REQ-006 SHALL have port mon_block  input  N_MON  block outputs of the per-instance deadlock monitors.
REQ-007 SHALL have port cfg_threshold  input  CNT_W  consecutive blocked cycles needed to confirm a deadlock; 0 treated as 1.
REQ-008 SHALL have port report_valid  output  1  deadlock report available.
REQ-009 SHALL have port report_ready  input  1  consumer accepts report.
REQ-010 SHALL have port report_idx  output  clog2(N_MON)  index of reported monitor.
REQ-011 SHALL have port report_cycles  output  CNT_W  persistence count of that monitor when selected.
REQ-012 SHALL have port deadlock  output  1  OR of all confirmed flags, registered.
REQ-013 SHALL have port busy  output  1  high while FSM is not IDLE.

Function
REQ-014 Per monitor i, cnt[i] SHALL increment by 1 each cycle mon_block[i]&enable is high, saturate at all-ones, and clear to 0 the cycle after mon_block[i] or enable is low.
REQ-015 confirmed[i] SHALL be cnt[i] >= max(cfg_threshold,1), evaluated every cycle against the current cfg_threshold.
REQ-016 pending[i] SHALL be confirmed[i] & ~reported[i].
REQ-017 FSM states SHALL be IDLE, SCAN, REPORT; reset state IDLE.
REQ-018 IDLE->SCAN when enable=1; SCAN->IDLE when enable=0 and no report is in progress.
REQ-019 In SCAN with any pending bit, a round-robin arbiter SHALL select the first pending index strictly after last_grant (wrapping N_MON-1->0), register report_idx and report_cycles=cnt[sel], and enter REPORT; report_valid SHALL be high the following cycle.
REQ-020 In REPORT, report_valid, report_idx, report_cycles SHALL remain stable until report_valid&report_ready; on that cycle reported[idx] sets, last_grant<=idx, FSM returns to SCAN.
REQ-021 reported[i] SHALL clear when mon_block[i] is low; if clear and set coincide, clear wins.
REQ-022 enable falling during REPORT SHALL NOT abort the handshake; FSM goes to IDLE after acceptance.
REQ-023 A monitor deasserting block while its report is pending SHALL NOT withdraw the report.
REQ-024 Minimum latency from first blocked cycle to report_valid SHALL be threshold+2 cycles for an uncontended monitor.
REQ-025 deadlock SHALL be registered OR of confirmed, one cycle after confirmation.

Reset
REQ-026 On reset, SHALL force: FSM=IDLE, all cnt=0, reported=0, last_grant=N_MON-1, report_valid=0, report_idx=0, report_cycles=0, deadlock=0, busy=0.
REQ-027 Reset mid-REPORT SHALL drop report_valid the next cycle without setting reported.

Structure
REQ-028 Package sobel_deadlock_pkg SHALL hold state encoding typedef, N_MON and CNT_W defaults, and index-width constant.
REQ-029 Round-robin selection SHALL be a separate sub-module sobel_deadlock_rr_arb (inputs req vector, last_grant; outputs gnt_valid, gnt_idx), purely combinational.

Verification
REQ-030 threshold=3, mon_block[2] high from cycle 0, ready=1 -> report_valid at cycle 5, idx=2, cycles=3; deadlock=1 at cycle 4.
REQ-031 threshold=2, blocks 0,1,3 held high, ready=1 -> reports in order 0,1,3, each one exactly once while held.
REQ-032 report_ready held 0 for 10 cycles -> valid, idx, cycles stable throughout; accepted on first ready.
REQ-033 mon_block[1] high 2 cycles, low 1, high 2 with threshold=3 -> no report, deadlock=0.
REQ-034 threshold=0, mon_block[0] pulses once -> report idx=0, cycles=1; re-block after release -> second report.
REQ-035 reset asserted during REPORT -> report_valid=0 next cycle, all counters 0, re-reporting resumes after deassert.
